mux_scan_sequencer: RTL and testbench

- Upstream/downstream companion to the 4:1 mux stage: drives the mux select `s`, dwells on each channel, samples the mux `out` back and assembles a parallel NUM_CH-bit snapshot.
- Performs single-pass or continuous scans on a `start` request.
- Produces a one-cycle `valid` pulse per completed pass.

---
 rtl/mux_scan_if.sv | 27 ++
 rtl/mux_scan_sequencer.sv | 115 +++++++++++
 tb/tb_mux_scan_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_if.sv
// Bus between the scan sequencer and its environment: the mux stage output
// coming back, the select going out, and the snapshot/status outputs.
// The sequencer takes the slave side; the environment (mux stage and
// consumer) takes the master side.
interface mux_scan_if #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
);
  logic              start;
  logic              mode;
  logic              mux_out;
  logic [SEL_W-1:0]  s;
  logic [NUM_CH-1:0] sample;
  logic              valid;
  logic              busy;
  logic              chg;

  modport master (
    output start, mode, mux_out,
    input  s, sample, valid, busy, chg
  );

  modport slave (
    input  start, mode, mux_out,
    output s, sample, valid, busy, chg
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Mux scan sequencer: steps the mux select through every channel, dwells
// DWELL cycles on each, captures the mux output on the last dwell cycle and
// publishes a NUM_CH-bit snapshot with a one-cycle valid pulse per pass.
// Single-pass or continuous operation, chosen by mode at each end of pass.
// Optional macro SCAN_CHG_EN: when defined, chg pulses with valid if the new
// snapshot differs from the previous one; otherwise chg is tied low.
module mux_scan_sequencer #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2,
  parameter int DWELL  = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  mux_scan_if.slave bus
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state_q;
  logic [SEL_W-1:0]  s_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [NUM_CH-1:0] shadow_q;
  logic [NUM_CH-1:0] sample_q;
  logic              valid_q;
  logic              busy_q;

  logic [NUM_CH-1:0] sample_d;
  logic              capture;
  logic              end_of_pass;

  // Next snapshot: shadow bits so far, last channel taken straight from the mux.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    sample_d             = shadow_q;
    sample_d[NUM_CH-1]   = bus.mux_out;
    capture              = (state_q == SCAN) && (cnt_q == LAST_CNT);
    end_of_pass          = capture && (s_q == LAST_CH);
  end

  // Scan FSM: select stepping, dwell counting, capture and snapshot publish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      s_q      <= '0;
      cnt_q    <= '0;
      // NOTE: the shadow is a small flop vector, so it is reset like any
      // other state; a scan aborted by reset leaves nothing behind.
      shadow_q <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register samples
      // the pre-edge values, independent of statement order.
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          s_q   <= '0;
          cnt_q <= '0;
          if (bus.start) begin
            state_q <= SCAN;
            busy_q  <= 1'b1;
          end
        end
        SCAN: begin
          if (capture) begin
            cnt_q         <= '0;
            shadow_q[s_q] <= bus.mux_out;
            if (end_of_pass) begin
              sample_q <= sample_d;
              valid_q  <= 1'b1;
              s_q      <= '0;
              if (!bus.mode) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              s_q <= s_q + SEL_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SCAN_CHG_EN
  logic chg_q;

  // Change flag: pulses with valid when the new snapshot differs from the old.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_q <= 1'b0;
    end else begin
      chg_q <= end_of_pass && (sample_d != sample_q);
    end
  end

  assign bus.chg = chg_q;
`else
  assign bus.chg = 1'b0;
`endif

  assign bus.s      = s_q;
  assign bus.sample = sample_q;
  assign bus.valid  = valid_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Testbench for mux_scan_sequencer. A behavioural model tracks each pass as
// a phase count 0..NUM_CH*DWELL-1 and derives select, captures and snapshot
// arithmetically; all outputs are compared on every falling edge. Directed
// sequences pin the model with literal values, then randomized traffic
// (start, mode, mux inputs, occasional async reset) runs against the model.
// A second instance with DWELL=1 is checked with literal expectations.
module tb_mux_scan_sequencer;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int DWELL  = 2;
  localparam int PASS   = NUM_CH * DWELL;
`ifdef SCAN_CHG_EN
  localparam bit CHG_ON = 1'b1;
`else
  localparam bit CHG_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [NUM_CH-1:0] mux_in;
  logic [NUM_CH-1:0] mux_in1;

  mux_scan_if #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) bus  ();
  mux_scan_if #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) bus1 ();

  // The 4:1 mux stages being scanned.
  assign bus.mux_out  = mux_in[bus.s];
  assign bus1.mux_out = mux_in1[bus1.s];

  mux_scan_sequencer #(.NUM_CH(NUM_CH), .SEL_W(SEL_W), .DWELL(DWELL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  mux_scan_sequencer #(.NUM_CH(NUM_CH), .SEL_W(SEL_W), .DWELL(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  bit                m_busy;
  int                m_ph;
  logic [NUM_CH-1:0] m_snap;
  logic [NUM_CH-1:0] m_sample;
  bit                m_valid;
  bit                m_chg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy   = 1'b0;
    m_ph     = 0;
    m_snap   = '0;
    m_sample = '0;
    m_valid  = 1'b0;
    m_chg    = 1'b0;
  endtask

  // One rising edge of the reference behaviour.
  task automatic model_edge();
    logic [NUM_CH-1:0] nxt;
    m_valid = 1'b0;
    m_chg   = 1'b0;
    if (!m_busy) begin
      if (bus.start) begin
        m_busy = 1'b1;
        m_ph   = 0;
      end
    end else begin
      if (m_ph % DWELL == DWELL - 1) m_snap[m_ph / DWELL] = mux_in[m_ph / DWELL];
      m_ph++;
      if (m_ph == PASS) begin
        nxt      = m_snap;
        m_chg    = CHG_ON && (nxt != m_sample);
        m_sample = nxt;
        m_valid  = 1'b1;
        m_ph     = 0;
        if (!bus.mode) m_busy = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    check("s",      bus.s,      m_busy ? m_ph / DWELL : 0);
    check("sample", bus.sample, m_sample);
    check("valid",  bus.valid,  m_valid);
    check("busy",   bus.busy,   m_busy);
    check("chg",    bus.chg,    m_chg);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  // Reset asserted mid low-phase; outputs must clear before any clock edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();
  endtask

  int seq2[8] = '{0, 0, 1, 1, 2, 2, 3, 3};

  initial begin
    bus.start  = 1'b0;
    bus.mode   = 1'b0;
    bus1.start = 1'b0;
    bus1.mode  = 1'b0;
    mux_in     = '0;
    mux_in1    = 4'b0110;
    rst_n      = 1'b1;
    model_reset();

    // Reset without any clock edge
    #2 rst_n = 1'b0;
    #1;
    compare_all();
    check("rst_sample_lit", bus.sample, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Single pass, DWELL=2, in=1010
    mux_in    = 4'b1010;
    bus.start = 1'b1;
    for (int j = 0; j < 8; j++) begin
      step();
      if (j == 0) bus.start = 1'b0;
      check("p1_s_seq", bus.s, seq2[j]);
    end
    step();
    check("p1_valid", bus.valid, 1'b1);
    check("p1_sample", bus.sample, 4'b1010);
    check("p1_busy", bus.busy, 1'b0);
    check("p1_s_end", bus.s, 0);
    step();
    check("p1_valid_drop", bus.valid, 1'b0);
    check("p1_sample_hold", bus.sample, 4'b1010);

    // Continuous: 1010, then 0110; mode drops during pass 3
    bus.mode  = 1'b1;
    bus.start = 1'b1;
    for (int e = 0; e <= 24; e++) begin
      step();
      if (e == 0) bus.start = 1'b0;
      if (e == 8) begin
        check("c1_valid", bus.valid, 1'b1);
        check("c1_sample", bus.sample, 4'b1010);
        check("c1_busy", bus.busy, 1'b1);
        mux_in = 4'b0110;
      end
      if (e == 16) begin
        check("c2_valid", bus.valid, 1'b1);
        check("c2_sample", bus.sample, 4'b0110);
        check("c2_busy", bus.busy, 1'b1);
        check("c2_chg", bus.chg, CHG_ON);
        bus.mode = 1'b0;
      end
      if (e == 24) begin
        check("c3_valid", bus.valid, 1'b1);
        check("c3_sample", bus.sample, 4'b0110);
        check("c3_busy", bus.busy, 1'b0);
      end
    end
    step();

    // Reset mid-scan: partial pass discarded, no valid
    mux_in    = 4'b1111;
    bus.start = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      step();
      if (e == 0) bus.start = 1'b0;
    end
    async_reset();
    check("mr_sample_lit", bus.sample, 4'b0000);
    check("mr_busy_lit", bus.busy, 1'b0);
    for (int e = 0; e < 10; e++) step();

    // Change flag: two identical single passes after reset
    mux_in = 4'b1010;
    for (int p = 0; p < 2; p++) begin
      bus.start = 1'b1;
      for (int e = 0; e <= 8; e++) begin
        step();
        if (e == 0) bus.start = 1'b0;
      end
      check("chg_pass_valid", bus.valid, 1'b1);
      check("chg_pass", bus.chg, CHG_ON && (p == 0));
      step();
    end

    // DWELL=1 instance: start re-asserted at edges 3 and 4 is ignored
    bus1.start = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      step();
      if (e < 4) begin
        check("d1_s", bus1.s, e);
        check("d1_busy", bus1.busy, 1'b1);
        check("d1_valid_lo", bus1.valid, 1'b0);
      end else if (e == 4) begin
        check("d1_s_wrap", bus1.s, 0);
        check("d1_valid", bus1.valid, 1'b1);
        check("d1_sample", bus1.sample, 4'b0110);
        check("d1_busy_end", bus1.busy, 1'b0);
      end else begin
        check("d1_idle_busy", bus1.busy, 1'b0);
        check("d1_idle_valid", bus1.valid, 1'b0);
      end
      if (e == 0) bus1.start = 1'b0;
      if (e == 2) bus1.start = 1'b1;
      if (e == 4) bus1.start = 1'b0;
    end

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      bus.start = ($urandom_range(0, 4) == 0);
      bus.mode  = ($urandom_range(0, 2) != 0);
      mux_in    = NUM_CH'($urandom);
      if ($urandom_range(0, 199) == 0) async_reset();
      else step();
    end
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    for (int e = 0; e < 2 * PASS; e++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
